lsu_bus_if: RTL and testbench

- Load/store unit sitting directly downstream of the core's ALU address output and upstream of the data memory bus.
- Accepts one load/store request from the core and drives a req/gnt/rvalid memory bus.
- Byte-lane steering, byte enables, and load sign/zero extension are handled here.
- Holds the core via req_ready/busy until the response returns.

---
 rtl/lsu_bus_if.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lsu_bus_if.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// lsu_bus_if: load/store unit between the core address/data path and a
// req/gnt/rvalid data memory bus. Takes one request at a time, steers store
// bytes onto lanes, generates byte enables, and extracts and extends load data.
//
// Optional build macro: LSU_MISALIGN_SPLIT_EN
//   undefined : any misaligned access completes with resp_err_o = 1 and no bus access
//   defined   : misaligned accesses run in hardware, word-crossing ones as two beats
//
// Parameter TIMEOUT: cycles in a WAIT state without rvalid before the access
// fails with an error. A value of 0 disables the timeout.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o  core request handshake (ready only while idle)
//   req_we_i             1 = store, 0 = load
//   req_addr_i           byte address
//   req_wdata_i          right-aligned store data
//   req_funct3_i         RV32I load/store funct3
//   resp_valid_o         one-cycle completion pulse
//   resp_rdata_o         extended load data (0 for stores and errors)
//   resp_err_o           access error, qualified by resp_valid_o
//   busy_o               high while an access is in flight
//   mem_req_o/gnt_i      bus request handshake
//   mem_addr_o           word address
//   mem_we_o, mem_be_o   bus write and byte enables
//   mem_wdata_o          lane-steered store data
//   mem_rvalid_i         bus response
//   mem_rdata_i          bus read data
//   mem_err_i            bus error, qualified by mem_rvalid_i
module lsu_bus_if #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_funct3_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, REQ2, WAIT2, RESP} state_e;

  state_e             state_q;
  logic               req_ready_q, busy_q;
  logic               resp_valid_q, resp_err_q;
  logic [31:0]        resp_rdata_q;
  logic               mem_req_q, mem_we_q;
  logic [3:0]         mem_be_q, be_hi_q;
  logic [31:0]        mem_addr_q, mem_wdata_q, rdata1_q;
  logic               we_q, split_q;
  logic [1:0]         off_q;
  logic [2:0]         funct3_q;
  logic [CNT_W-1:0]   cnt_q;

  // Request decode, evaluated on the incoming request while idle.
  logic [1:0]  req_off_c, req_sz_c;
  logic        illegal_c, misal_err_c, split_c;
  logic [3:0]  size_mask_c;
  logic [7:0]  be8_c;
  logic [31:0] wrep_c, wrot_c;

  assign req_off_c = req_addr_i[1:0];
  assign req_sz_c  = req_funct3_i[1:0];

  // Loads allow 0,1,2,4,5; stores allow 0,1,2.
  assign illegal_c = req_we_i ? (req_funct3_i >= 3'd3)
                              : ((req_sz_c == 2'd3) || (req_funct3_i == 3'd6));

`ifdef LSU_MISALIGN_SPLIT_EN
  assign split_c     = ((req_sz_c == 2'd1) && (req_off_c == 2'd3)) ||
                       ((req_sz_c == 2'd2) && (req_off_c != 2'd0));
  assign misal_err_c = 1'b0;
`else
  assign split_c     = 1'b0;
  assign misal_err_c = ((req_sz_c == 2'd1) && req_off_c[0]) ||
                       ((req_sz_c == 2'd2) && (req_off_c != 2'd0));
`endif

  always_comb begin
    size_mask_c = 4'b1111;
    wrep_c      = req_wdata_i;
    case (req_sz_c)
      2'd0: begin
        size_mask_c = 4'b0001;
        wrep_c      = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        size_mask_c = 4'b0011;
        wrep_c      = {2{req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Low nibble is the first-beat enable, high nibble the second beat.
  assign be8_c = {4'b0000, size_mask_c} << req_off_c;

  // Rotating the replicated data by the offset puts every byte on its lane
  // for both beats of a split access as well as for single accesses.
  always_comb begin
    wrot_c = wrep_c;
    case (req_off_c)
      2'd1:    wrot_c = {wrep_c[23:0], wrep_c[31:24]};
      2'd2:    wrot_c = {wrep_c[15:0], wrep_c[31:16]};
      2'd3:    wrot_c = {wrep_c[7:0],  wrep_c[31:8]};
      default: ;
    endcase
  end

  // Load extraction from the (possibly two-beat) read data.
  logic [31:0] rd_lo_c, rd_hi_c, rd_val_c, ld_data_c;
  logic [63:0] rd_cat_c;

  assign rd_lo_c  = (state_q == WAIT2) ? rdata1_q    : mem_rdata_i;
  assign rd_hi_c  = (state_q == WAIT2) ? mem_rdata_i : 32'd0;
  assign rd_cat_c = {rd_hi_c, rd_lo_c} >> {off_q, 3'b000};
  assign rd_val_c = rd_cat_c[31:0];

  always_comb begin
    ld_data_c = rd_val_c;
    case (funct3_q)
      3'd0:    ld_data_c = {{24{rd_val_c[7]}},  rd_val_c[7:0]};
      3'd1:    ld_data_c = {{16{rd_val_c[15]}}, rd_val_c[15:0]};
      3'd4:    ld_data_c = {24'd0, rd_val_c[7:0]};
      3'd5:    ld_data_c = {16'd0, rd_val_c[15:0]};
      default: ;
    endcase
  end

  logic [CNT_W-1:0] cnt_inc_c;
  logic             to_hit_c;

  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign to_hit_c  = TO_EN && (cnt_inc_c == CNT_W'(TIMEOUT));

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'd0;
      be_hi_q      <= 4'd0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      rdata1_q     <= 32'd0;
      we_q         <= 1'b0;
      split_q      <= 1'b0;
      off_q        <= 2'd0;
      funct3_q     <= 3'd0;
      cnt_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q        <= req_we_i;
            off_q       <= req_off_c;
            funct3_q    <= req_funct3_i;
            split_q     <= split_c;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (illegal_c || misal_err_c) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'd0;
            end else begin
              state_q     <= REQ;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_we_q    <= req_we_i;
              mem_be_q    <= be8_c[3:0];
              be_hi_q     <= be8_c[7:4];
              mem_wdata_q <= wrot_c;
            end
          end
        end
        REQ, REQ2: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= (state_q == REQ) ? WAIT : WAIT2;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (mem_err_i || !split_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= mem_err_i;
              resp_rdata_q <= (mem_err_i || we_q) ? 32'd0 : ld_data_c;
            end else begin
              // First beat of a split access done; issue the next word.
              rdata1_q   <= mem_rdata_i;
              state_q    <= REQ2;
              mem_req_q  <= 1'b1;
              mem_addr_q <= mem_addr_q + 32'd4;
              mem_be_q   <= be_hi_q;
            end
          end else if (to_hit_c) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        WAIT2: begin
          if (mem_rvalid_i) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= mem_err_i;
            resp_rdata_q <= (mem_err_i || we_q) ? 32'd0 : ld_data_c;
          end else if (to_hit_c) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'd0;
          end else begin
            cnt_q <= cnt_inc_c;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          busy_q       <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= 32'd0;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          mem_req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign busy_o       = busy_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed testbench for lsu_bus_if (TIMEOUT = 4).
module tb_lsu_bus_if;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  lsu_bus_if #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_funct3_i(req_funct3),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .busy_o(busy), .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_be !== 4'd0) begin bad++; $display("FAIL rst_mem_be got=%h exp=0", mem_be); end
    total++; if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_lw_aligned();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL lw_ready got=%b exp=1", req_ready); end
    issue(1'b0, 32'h100, 32'h0, 3'd2);
    // cycle 1
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lw_mem_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=00000100", mem_addr); end
    total++; if (mem_be !== 4'b1111) begin bad++; $display("FAIL lw_be got=%b exp=1111", mem_be); end
    total++; if (busy !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL lw_busy got=%b/%b exp=1/0", busy, req_ready); end
    mem_gnt = 1'b1;
    tick(); // cycle 2
    mem_gnt = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_req_drop got=%b exp=0", mem_req); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); // cycle 3
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL lw_resp_valid got=%b exp=1", resp_valid); end
    total++; if (resp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", resp_rdata); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", resp_err); end
    tick(); // cycle 4
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL lw_after got=%b/%b exp=0/1", resp_valid, req_ready); end
  endtask

  // One-beat load with immediate grant and response; checks be and data.
  task automatic test_load_ext();
    logic [2:0]  f3s [4]  = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] adrs[4]  = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [3:0]  bes [4]  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
    logic [31:0] exps[4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, adrs[i], 32'h0, f3s[i]);
      total++; if (mem_be !== bes[i]) begin bad++; $display("FAIL ld%0d_be got=%b exp=%b", i, mem_be, bes[i]); end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF1234;
      tick();
      mem_rvalid = 1'b0;
      total++; if (resp_valid !== 1'b1 || resp_rdata !== exps[i]) begin bad++; $display("FAIL ld%0d_rdata got=%b/%h exp=1/%h", i, resp_valid, resp_rdata, exps[i]); end
      tick();
    end
  endtask

  task automatic test_store_stall();
    issue(1'b1, 32'h202, 32'h0000ABCD, 3'd1);
    for (int c = 0; c < 4; c++) begin
      total++; if (mem_req !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_we !== 1'b1 || mem_addr !== 32'h200) begin
        bad++; $display("FAIL sh_hold%0d got=req%b be%b wd%h we%b a%h exp=req1 be1100 wdabcdabcd we1 a200", c, mem_req, mem_be, mem_wdata, mem_we, mem_addr);
      end
      if (c == 3) begin mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111; end
      tick();
    end
    // WAIT, first cycle: rvalid in the grant cycle must have been ignored.
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL sh_gnt_rvalid got=%b/%b exp=0/1", resp_valid, busy); end
    tick();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'd0) begin bad++; $display("FAIL sh_resp got=%b/%b/%h exp=1/0/0", resp_valid, resp_err, resp_rdata); end
    tick();
    issue(1'b1, 32'h201, 32'h12345678, 3'd0);
    total++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h78787878) begin bad++; $display("FAIL sb_lane got=%b/%h exp=0010/78787878", mem_be, mem_wdata); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0; tick();
  endtask

  task automatic test_illegal();
    issue(1'b0, 32'h100, 32'h0, 3'd3);
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL ill_ld got=%b/%b/%b exp=1/1/0", resp_valid, resp_err, mem_req); end
    tick();
    issue(1'b1, 32'h100, 32'h0, 3'd4);
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL ill_st got=%b/%b/%b exp=1/1/0", resp_valid, resp_err, mem_req); end
    tick();
  endtask

  task automatic test_misaligned();
    issue(1'b0, 32'h101, 32'h0, 3'd2);
`ifdef LSU_MISALIGN_SPLIT_EN
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_be !== 4'b1110) begin bad++; $display("FAIL mis_beat1 got=%b/%h/%b exp=1/100/1110", mem_req, mem_addr, mem_be); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h44332211; tick(); mem_rvalid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104 || mem_be !== 4'b0001) begin bad++; $display("FAIL mis_beat2 got=%b/%h/%b exp=1/104/0001", mem_req, mem_addr, mem_be); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h88776655; tick(); mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'h55443322) begin bad++; $display("FAIL mis_resp got=%b/%b/%h exp=1/0/55443322", resp_valid, resp_err, resp_rdata); end
`else
    total++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%b/%b/%b exp=0/1/1", mem_req, resp_valid, resp_err); end
`endif
    tick();
  endtask

  task automatic test_timeout();
    issue(1'b0, 32'h100, 32'h0, 3'd2);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL to_early%0d got=%b exp=0", c, resp_valid); end
      tick();
    end
    total++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin bad++; $display("FAIL to_resp got=%b/%b/%h exp=1/1/0", resp_valid, resp_err, resp_rdata); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick(); tick();
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL to_idle_rvalid got=%b/%b/%b exp=0/0/0", resp_valid, busy, mem_req); end
  endtask

  task automatic test_reset_in_wait();
    issue(1'b0, 32'h100, 32'h0, 3'd2);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'd0 || mem_be !== 4'd0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rstw_clear got=%b/%h/%b/%b/%b exp=0/0/0/0/0", mem_req, mem_addr, mem_be, resp_valid, busy);
    end
    mem_rvalid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL rstw_after got=%b/%b exp=0/1", resp_valid, req_ready); end
    tick();
    total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstw_idle got=%b/%b exp=0/0", resp_valid, busy); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_funct3 = 3'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0; mem_err = 1'b0;
    test_reset();
    test_lw_aligned();
    test_load_ext();
    test_store_stall();
    test_illegal();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
